// File: rtl/c17_pkg.sv
// Shared C17 operand/result types and the reference evaluation function.
package c17_pkg;

  localparam int unsigned OPW  = 5;
  localparam int unsigned RESW = 2;

  localparam int unsigned G1_B = 0;
  localparam int unsigned G2_B = 1;
  localparam int unsigned G3_B = 2;
  localparam int unsigned G6_B = 3;
  localparam int unsigned G7_B = 4;

  localparam int unsigned G22_B = 0;
  localparam int unsigned G23_B = 1;

  typedef logic [OPW-1:0]  c17_op_t;
  typedef logic [RESW-1:0] c17_res_t;

  // ISCAS C17 netlist reduced to two output equations sharing n8.
  function automatic c17_res_t c17_eval(input c17_op_t op);
    logic     n8;
    c17_res_t res;
    n8         = op[G6_B] & op[G3_B];
    res        = '0;
    res[G22_B] = (op[G2_B] & ~n8) | (op[G1_B] & op[G3_B]);
    res[G23_B] = (op[G2_B] & ~n8) | (op[G7_B] & ~n8);
    return res;
  endfunction

endpackage

// File: rtl/c17_rr_grant.sv
// Combinational round-robin select: first requester at or above ptr, wrapping at NREQ.
module c17_rr_grant #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned j;
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[IDW'(j)]) begin
        any             = 1'b1;
        idx             = IDW'(j);
        grant[IDW'(j)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c17_share_arbiter.sv
// Round-robin shared C17 evaluator: operand register, result register, id-tagged responses.
module c17_share_arbiter
  import c17_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ),
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  output logic [RESW-1:0]     resp_data,
  output logic [IDW-1:0]      resp_id,
  input  logic                resp_ready,
  output logic [CNTW-1:0]     op_count
);

  c17_op_t         req_op [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt;

  logic            s1_valid;
  c17_op_t         s1_op;
  logic [IDW-1:0]  s1_id;
  logic            s2_valid;

  logic            adv1;
  logic            adv2;
  logic            accept;

  for (genvar i = 0; i < NREQ; i++) begin : g_op
    assign req_op[i] = req_data[i*OPW +: OPW];
  end

  c17_rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_grant (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Stage 2 frees when empty or draining; stage 1 frees when empty or stage 2 takes it.
  assign adv2       = !s2_valid | resp_ready;
  assign adv1       = !s1_valid | adv2;
  assign accept     = grant_any & adv1 & !rst;
  assign req_ready  = rst ? '0 : (grant & {NREQ{adv1}});
  assign resp_valid = s2_valid;
  assign ptr_nxt    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op <= req_op[grant_idx];
        s1_id <= grant_idx;
        ptr   <= ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      resp_data <= '0;
      resp_id   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        resp_data <= c17_eval(s1_op);
        resp_id   <= s1_id;
      end
    end
  end

  // Completed-response counter, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (s2_valid && resp_ready && !(&op_count)) begin
      op_count <= op_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_c17_share_arbiter.sv
// Bench for c17_share_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_c17_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;
  localparam int CMAX = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*5-1:0]   req_data;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic [1:0]          resp_data;
  logic [IDW-1:0]      resp_id;
  logic                resp_ready;
  logic [CNTW-1:0]     op_count;

  int n_pass  = 0;
  int n_total = 0;

  c17_share_arbiter #(
    .NREQ (NREQ),
    .CNTW (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Model: in-flight items in acceptance order; an item is presented once it is
  // the oldest and has seen two edges since acceptance. Pipeline holds two items.
  typedef struct {
    int         id;
    logic [1:0] res;
    int         age;
  } item_t;

  item_t           m_q[$];
  int              m_ptr;
  int              m_count;
  logic            exp_rvalid;
  logic [1:0]      exp_data;
  int              exp_id;
  int              exp_gid;
  logic [NREQ-1:0] exp_ready;

  function automatic logic [1:0] ref_c17(input logic [4:0] op);
    logic g1, g2, g3, g6, g7, n8;
    {g7, g6, g3, g2, g1} = op;
    n8 = g6 & g3;
    return {(g2 & ~n8) | (g7 & ~n8), (g2 & ~n8) | (g1 & g3)};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ptr   = 0;
    m_count = 0;
  endtask

  task automatic model_eval();
    exp_rvalid = (m_q.size() > 0) && (m_q[0].age >= 2);
    exp_data   = exp_rvalid ? m_q[0].res : 2'b00;
    exp_id     = exp_rvalid ? m_q[0].id : 0;
    exp_gid    = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (exp_gid < 0 && req_valid[j]) exp_gid = j;
    end
    exp_ready = '0;
    if (!rst && exp_gid >= 0 && (m_q.size() < 2 || resp_ready)) exp_ready[exp_gid] = 1'b1;
  endtask

  task automatic model_commit();
    if (exp_rvalid && resp_ready) begin
      void'(m_q.pop_front());
      if (m_count < CMAX) m_count++;
    end
    foreach (m_q[i]) m_q[i].age++;
    if (exp_ready != '0) begin
      item_t it;
      it.id  = exp_gid;
      it.res = ref_c17(req_data[exp_gid*5 +: 5]);
      it.age = 1;
      m_q.push_back(it);
      m_ptr = (exp_gid + 1) % NREQ;
    end
  endtask

  task automatic pre();
    @(negedge clk);
    model_eval();
  endtask

  task automatic post();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '1;
    req_data   = 20'($urandom);
    resp_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
    n_total++; if (resp_data !== 2'b00) $display("FAIL reset_resp_data: got %b want 00", resp_data); else n_pass++;
    n_total++; if (resp_id !== 2'd0) $display("FAIL reset_resp_id: got %0d want 0", resp_id); else n_pass++;
    n_total++; if (op_count !== 4'd0) $display("FAIL reset_op_count: got %0d want 0", op_count); else n_pass++;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single_op();
    req_data        = '0;
    req_data[14:10] = 5'b00010;
    req_valid       = 4'b0100;
    resp_ready      = 1'b1;
    pre();
    n_total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else n_pass++;
    post();
    req_valid = '0;
    pre();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", resp_valid); else n_pass++;
    post();
    pre();
    n_total++; if (resp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", resp_valid); else n_pass++;
    n_total++; if (resp_data !== 2'b11) $display("FAIL single_data: got %b want 11", resp_data); else n_pass++;
    n_total++; if (resp_id !== 2'd2) $display("FAIL single_id: got %0d want 2", resp_id); else n_pass++;
    post();
    pre();
    n_total++; if (op_count !== 4'd1) $display("FAIL single_count: got %0d want 1", op_count); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL single_drained: got %b want 0", resp_valid); else n_pass++;
    post();
  endtask

  task automatic test_function_vectors();
    logic [4:0] ops [3];
    logic [1:0] res [3];
    ops = '{5'b01100, 5'b00101, 5'b10000};
    res = '{2'b00, 2'b01, 2'b10};
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_data = '0;
      if (c < 3) begin
        req_valid     = 4'b0001;
        req_data[4:0] = ops[c];
      end else begin
        req_valid = '0;
      end
      pre();
      if (c < 3) begin
        n_total++; if (req_ready !== 4'b0001) $display("FAIL fv_ready[%0d]: got %b want 0001", c, req_ready); else n_pass++;
      end
      if (c >= 2 && c < 5) begin
        n_total++; if (resp_valid !== 1'b1) $display("FAIL fv_valid[%0d]: got %b want 1", c, resp_valid); else n_pass++;
        n_total++; if (resp_data !== res[c-2]) $display("FAIL fv_data[%0d]: got %b want %b", c, resp_data, res[c-2]); else n_pass++;
        n_total++; if (resp_id !== 2'd0) $display("FAIL fv_id[%0d]: got %0d want 0", c, resp_id); else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (resp_valid !== 1'b0) $display("FAIL fv_idle: got %b want 0", resp_valid); else n_pass++;
      end
      post();
    end
  endtask

  task automatic test_fairness();
    logic [1:0] fres [4];
    fres = '{2'b11, 2'b01, 2'b10, 2'b00};
    apply_reset();
    req_data   = {5'b01100, 5'b10000, 5'b00101, 5'b00010};
    resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      pre();
      if (c < 8) begin
        n_total++; if (req_ready !== 4'(1 << (c % 4))) $display("FAIL fair_grant[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4))); else n_pass++;
      end
      if (c >= 2) begin
        n_total++; if (resp_valid !== 1'b1) $display("FAIL fair_valid[%0d]: got %b want 1", c, resp_valid); else n_pass++;
        n_total++; if (resp_id !== 2'((c - 2) % 4)) $display("FAIL fair_id[%0d]: got %0d want %0d", c, resp_id, (c - 2) % 4); else n_pass++;
        n_total++; if (resp_data !== fres[(c - 2) % 4]) $display("FAIL fair_data[%0d]: got %b want %b", c, resp_data, fres[(c - 2) % 4]); else n_pass++;
      end
      post();
    end
  endtask

  task automatic test_backpressure();
    int         p0;
    int         accepts;
    logic [1:0] frz_data;
    logic [1:0] frz_id;
    p0         = m_ptr;
    accepts    = 0;
    frz_data   = '0;
    frz_id     = '0;
    req_valid  = 4'b1111;
    req_data   = 20'($urandom);
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pre();
      if (req_ready != '0) accepts++;
      if (c >= 2) begin
        n_total++; if (req_ready !== 4'b0000) $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, req_ready); else n_pass++;
      end
      if (c == 2) begin
        frz_data = resp_data;
        frz_id   = resp_id;
        n_total++; if (resp_id !== 2'(p0)) $display("FAIL bp_head_id: got %0d want %0d", resp_id, p0); else n_pass++;
        n_total++; if (resp_data !== exp_data) $display("FAIL bp_head_data: got %b want %b", resp_data, exp_data); else n_pass++;
      end
      if (c > 2) begin
        n_total++; if ({resp_valid, resp_data, resp_id} !== {1'b1, frz_data, frz_id})
          $display("FAIL bp_frozen[%0d]: got %b/%b/%0d want 1/%b/%0d", c, resp_valid, resp_data, resp_id, frz_data, frz_id); else n_pass++;
      end
      post();
    end
    n_total++; if (accepts !== 2) $display("FAIL bp_accepts: got %0d want 2", accepts); else n_pass++;
    resp_ready = 1'b1;
    pre();
    n_total++; if (req_ready !== 4'(1 << ((p0 + 2) % 4))) $display("FAIL bp_ptr_held: got %b want %b", req_ready, 4'(1 << ((p0 + 2) % 4))); else n_pass++;
    n_total++; if (resp_id !== 2'(p0)) $display("FAIL bp_drain0: got %0d want %0d", resp_id, p0); else n_pass++;
    post();
    req_valid = '0;
    for (int c = 1; c < 3; c++) begin
      pre();
      n_total++; if ({resp_valid, resp_id} !== {1'b1, 2'((p0 + c) % 4)})
        $display("FAIL bp_drain%0d: got %b/%0d want 1/%0d", c, resp_valid, resp_id, (p0 + c) % 4); else n_pass++;
      post();
    end
    pre();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", resp_valid); else n_pass++;
    post();
  endtask

  task automatic test_reset_mid();
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      pre();
      post();
    end
    pre();
    n_total++; if ({resp_valid, req_ready} !== {1'b1, 4'b0000}) $display("FAIL rm_full: got %b/%b want 1/0000", resp_valid, req_ready); else n_pass++;
    post();
    #3;
    rst = 1'b1;
    #1;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL rm_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL rm_req_ready: got %b want 0000", req_ready); else n_pass++;
    n_total++; if (op_count !== 4'd0) $display("FAIL rm_op_count: got %0d want 0", op_count); else n_pass++;
    m_reset();
    @(posedge clk);
    #1;
    rst             = 1'b0;
    req_valid       = 4'b1000;
    req_data        = '0;
    req_data[19:15] = 5'b00101;
    resp_ready      = 1'b1;
    pre();
    n_total++; if (req_ready !== 4'b1000) $display("FAIL rm_first_grant: got %b want 1000", req_ready); else n_pass++;
    post();
    req_valid = '0;
    pre();
    post();
    pre();
    n_total++; if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd3, 2'b01})
      $display("FAIL rm_first_resp: got %b/%0d/%b want 1/3/01", resp_valid, resp_id, resp_data); else n_pass++;
    post();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      req_valid  = 4'($urandom);
      req_data   = 20'($urandom);
      resp_ready = ($urandom % 4) != 0;
      pre();
      n_total++; if (req_ready !== exp_ready) $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_ready); else n_pass++;
      n_total++; if (resp_valid !== exp_rvalid) $display("FAIL rnd_valid[%0d]: got %b want %b", c, resp_valid, exp_rvalid); else n_pass++;
      if (exp_rvalid) begin
        n_total++; if ({resp_id, resp_data} !== {2'(exp_id), exp_data})
          $display("FAIL rnd_resp[%0d]: got %0d/%b want %0d/%b", c, resp_id, resp_data, exp_id, exp_data); else n_pass++;
      end
      n_total++; if (op_count !== 4'(m_count)) $display("FAIL rnd_count[%0d]: got %0d want %0d", c, op_count, m_count); else n_pass++;
      post();
    end
  endtask

  task automatic test_saturation();
    int done;
    apply_reset();
    done       = 0;
    req_valid  = 4'b1111;
    req_data   = 20'($urandom);
    resp_ready = 1'b1;
    for (int c = 0; c < 40 && done < 20; c++) begin
      pre();
      n_total++; if (op_count !== 4'((done > CMAX) ? CMAX : done)) $display("FAIL sat_count[%0d]: got %0d want %0d", c, op_count, (done > CMAX) ? CMAX : done); else n_pass++;
      if (exp_rvalid) done++;
      post();
    end
    req_valid = '0;
    pre();
    n_total++; if (op_count !== 4'd15) $display("FAIL sat_final: got %0d want 15 after %0d responses", op_count, done); else n_pass++;
    post();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_function_vectors();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
